act_nz_fetch: RTL and testbench

- Downstream consumer of the PE activation register file pair.
- On a start pulse, snapshots the input-activation zero flags and walks only the non-zero entries in ascending address order.
- Issues register-file reads for those entries and streams (index, value) pairs to the PE MAC datapath over a valid/ready interface.
- Zero-skipping is the point: zero activations cost no cycles.

---
 rtl/act_nz_fetch_pkg.sv | 17 +
 rtl/act_nz_fifo2.sv | 45 ++++
 rtl/act_nz_fetch.sv | 124 ++++++++++++
 tb/tb_act_nz_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_nz_fetch_pkg.sv
// Shared constants and FSM encoding for the zero-skipping activation fetcher.
package act_nz_fetch_pkg;

  localparam int PE_ACT_NO     = 16;
  localparam int PE_DATA_WIDTH = 16;

  localparam int ACT_NO     = PE_ACT_NO;
  localparam int ADDR_WIDTH = $clog2(ACT_NO);
  localparam int DATA_WIDTH = PE_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } act_state_e;

endpackage

// File: rtl/act_nz_fifo2.sv
// Two-entry synchronous FIFO; push and pop may coincide, head is always visible.
module act_nz_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/act_nz_fetch.sv
// Walks the non-zero activations of a snapshotted zero mask in ascending order,
// reads them from the register file and streams {idx, data, last} downstream.
//
// act_valid/act_ready: an entry transfers on a cycle where both are high; while
// act_valid is high and act_ready low, act_idx/act_data/act_last hold stable.
module act_nz_fetch
  import act_nz_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ACT_NO-1:0]     in_act_zeros,
  output logic                  in_act_read_en,
  output logic [ADDR_WIDTH-1:0] in_act_read_addr,
  input  logic [DATA_WIDTH-1:0] in_act_read_data,
  output logic                  act_valid,
  input  logic                  act_ready,
  output logic [ADDR_WIDTH-1:0] act_idx,
  output logic [DATA_WIDTH-1:0] act_data,
  output logic                  act_last,
  output logic                  busy,
  output logic                  done,
  output act_state_e            dbg_state
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;

  function automatic logic [ADDR_WIDTH-1:0] lowest_set(input logic [ACT_NO-1:0] m);
    logic [ADDR_WIDTH-1:0] r;
    r = '0;
    for (int i = ACT_NO - 1; i >= 0; i--) begin
      if (m[i]) r = ADDR_WIDTH'(i);
    end
    return r;
  endfunction

  act_state_e            state_q, state_d;
  logic [ACT_NO-1:0]     pending_q, pending_d;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] infl_addr_q;
  logic                  infl_last_q;

  logic                  issue;
  logic                  issue_last;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  pop;
  logic [1:0]            fifo_count;
  logic [EW-1:0]         head;
  logic                  head_last;
  logic [2:0]            occ;

  assign pop       = act_valid & act_ready;
  assign head_last = head[0];
  // Entries already committed downstream once this cycle's handshake retires.
  assign occ       = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    rd_addr    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pending_d = ~in_act_zeros;
          state_d   = (in_act_zeros != '1) ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        if (pending_q != '0 && occ < 3'd2) begin
          issue      = 1'b1;
          rd_addr    = lowest_set(pending_q);
          pending_d  = pending_q & ~(ACT_NO'(1) << rd_addr);
          issue_last = (pending_d == '0);
        end
        if (pop && head_last) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      inflight_q <= issue;
      if (issue) begin
        infl_addr_q <= rd_addr;
        infl_last_q <= issue_last;
      end
    end
  end

  act_nz_fifo2 #(.W(EW)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({infl_addr_q, in_act_read_data, infl_last_q}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign in_act_read_en   = issue;
  assign in_act_read_addr = rd_addr;
  assign act_valid        = (fifo_count != 2'd0);
  assign act_idx          = head[EW-1 -: ADDR_WIDTH];
  assign act_data         = head[DATA_WIDTH:1];
  assign act_last         = act_valid & head_last;
  assign busy             = (state_q == ST_RUN) || (state_q == ST_FIN);
  assign done             = (state_q == ST_FIN);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_act_nz_fetch.sv
// Directed bench for act_nz_fetch: register-file model, expected-entry queues,
// a per-cycle compare process and literal timing checks per pass.
module tb_act_nz_fetch;
  import act_nz_fetch_pkg::*;

  localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ACT_NO-1:0]     in_act_zeros;
  logic                  in_act_read_en;
  logic [ADDR_WIDTH-1:0] in_act_read_addr;
  logic [DATA_WIDTH-1:0] in_act_read_data;
  logic                  act_valid;
  logic                  act_ready;
  logic [ADDR_WIDTH-1:0] act_idx;
  logic [DATA_WIDTH-1:0] act_data;
  logic                  act_last;
  logic                  busy;
  logic                  done;
  act_state_e            dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  act_nz_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .in_act_zeros     (in_act_zeros),
    .in_act_read_en   (in_act_read_en),
    .in_act_read_addr (in_act_read_addr),
    .in_act_read_data (in_act_read_data),
    .act_valid        (act_valid),
    .act_ready        (act_ready),
    .act_idx          (act_idx),
    .act_data         (act_data),
    .act_last         (act_last),
    .busy             (busy),
    .done             (done),
    .dbg_state        (dbg_state)
  );

  // Register file: data appears one cycle after the read enable.
  logic [DATA_WIDTH-1:0] rf_mem [ACT_NO];
  always @(posedge clk)
    in_act_read_data <= in_act_read_en ? rf_mem[in_act_read_addr] : 16'hDEAD;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [EW-1:0]         exp_q[$];
  logic [ADDR_WIDTH-1:0] exp_addr_q[$];
  bit                    model_busy = 0;
  bit                    done_due = 0;
  bit                    armed = 0;
  bit                    stall_prev = 0;
  logic [EW-1:0]         head_prev;
  int                    outstanding = 0;

  int hs_idx_q[$];
  int first_valid_cyc, last_hs_cyc, done_cyc, start_cyc, rd_cnt;

  // Expected stream: every non-zero entry, ascending, last flag on the highest one.
  function automatic void build_pass(input logic [ACT_NO-1:0] zeros);
    int hi;
    hi = -1;
    for (int i = 0; i < ACT_NO; i++) if (!zeros[i]) hi = i;
    for (int i = 0; i < ACT_NO; i++) begin
      if (!zeros[i]) begin
        exp_addr_q.push_back(ADDR_WIDTH'(i));
        exp_q.push_back({ADDR_WIDTH'(i), rf_mem[i], (i == hi)});
      end
    end
  endfunction

  always @(negedge clk) begin
    logic pop;
    bit   busy_cur;
    bit   hs_last;
    pop      = (act_valid === 1'b1) && (act_ready === 1'b1);
    busy_cur = model_busy;
    hs_last  = 0;
    if (armed) begin
      check("busy", busy, model_busy);
      check("done", done, done_due);
      if (done === 1'b1) done_cyc = cyc;
      if (stall_prev) begin
        check("stall_valid", act_valid, 1);
        check("stall_head", {act_idx, act_data, act_last}, head_prev);
      end
      if (act_valid === 1'b1) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("act_entry", {act_idx, act_data, act_last}, exp_q[0]);
        if (pop) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hs_idx_q.push_back(int'(act_idx));
          last_hs_cyc = cyc;
          outstanding--;
          hs_last = (act_last === 1'b1);
        end
      end else begin
        check("last_idle", act_last, 0);
      end
      if (in_act_read_en === 1'b1) begin
        rd_cnt++;
        check("read_window", outstanding < 2, 1);
        if (exp_addr_q.size() == 0) check("unexpected_read", 1, 0);
        else check("read_addr", in_act_read_addr, exp_addr_q.pop_front());
        outstanding++;
      end
      if (done_due) begin
        model_busy = 0;
        done_due   = 0;
      end
      if (hs_last) done_due = 1;
      if (!busy_cur && start === 1'b1 && rst !== 1'b1) begin
        start_cyc  = cyc;
        model_busy = 1;
        build_pass(in_act_zeros);
        if (in_act_zeros == '1) done_due = 1;
      end
      stall_prev = (act_valid === 1'b1) && (act_ready !== 1'b1);
      head_prev  = {act_idx, act_data, act_last};
    end
    if (rst === 1'b1) begin
      armed       = 1;
      exp_q.delete();
      exp_addr_q.delete();
      model_busy  = 0;
      done_due    = 0;
      outstanding = 0;
      stall_prev  = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    hs_idx_q.delete();
    first_valid_cyc = -1;
    last_hs_cyc     = -1;
    done_cyc        = -1;
    start_cyc       = -1;
    rd_cnt          = 0;
  endtask

  task automatic pulse_start(input logic [ACT_NO-1:0] zeros);
    @(posedge clk); #1;
    in_act_zeros = zeros;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 400 && done_cyc < 0; n++) @(posedge clk);
    if (done_cyc < 0) check(name, 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; in_act_zeros = '1; act_ready = 1'b0;
    for (int i = 0; i < ACT_NO; i++) rf_mem[i] = DATA_WIDTH'(i * 7 + 1);
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", act_valid, 0);
    check("rst_read_en", in_act_read_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", act_last, 0);
    check("rst_idx", act_idx, 0);
    check("rst_data", act_data, 0);

    // All-zero mask: done immediately, no reads.
    clear_logs();
    pulse_start(16'hFFFF);
    wait_done("allzero_timeout");
    check("allzero_done_cyc", done_cyc, start_cyc + 1);
    check("allzero_reads", rd_cnt, 0);
    check("allzero_no_valid", first_valid_cyc, -1);

    // Sparse mask 0xFF5A -> idx 0,2,5,7 back to back.
    for (int i = 0; i < ACT_NO; i++) rf_mem[i] = DATA_WIDTH'(16'hA000 + i);
    act_ready = 1'b1;
    clear_logs();
    pulse_start(16'hFF5A);
    wait_done("sparse_timeout");
    check("sparse_count", hs_idx_q.size(), 4);
    if (hs_idx_q.size() == 4) begin
      check("sparse_idx0", hs_idx_q[0], 0);
      check("sparse_idx1", hs_idx_q[1], 2);
      check("sparse_idx2", hs_idx_q[2], 5);
      check("sparse_idx3", hs_idx_q[3], 7);
    end
    check("sparse_first_valid", first_valid_cyc, start_cyc + 3);
    check("sparse_last_hs", last_hs_cyc, start_cyc + 6);
    check("sparse_done", done_cyc, start_cyc + 7);
    check("sparse_drained", exp_q.size(), 0);

    // Full mask with ready toggling every cycle.
    for (int i = 0; i < ACT_NO; i++) rf_mem[i] = DATA_WIDTH'(i * 3);
    clear_logs();
    pulse_start(16'h0000);
    for (int n = 0; n < 400 && done_cyc < 0; n++) begin
      @(posedge clk); #1 act_ready = ~act_ready;
    end
    act_ready = 1'b1;
    wait_done("toggle_timeout");
    check("toggle_count", hs_idx_q.size(), 16);
    for (int k = 0; k < hs_idx_q.size(); k++) check("toggle_order", hs_idx_q[k], k);
    check("toggle_done", done_cyc, last_hs_cyc + 1);

    // Restart attempt and mask change mid-pass are ignored.
    for (int i = 0; i < ACT_NO; i++) rf_mem[i] = DATA_WIDTH'(i * 5 + 2);
    clear_logs();
    pulse_start(16'h00F0);
    @(posedge clk); #1;
    in_act_zeros = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_act_zeros = 16'h0F0F;
    wait_done("restart_timeout");
    check("restart_count", hs_idx_q.size(), 12);
    if (hs_idx_q.size() == 12) begin
      check("restart_idx4", hs_idx_q[4], 8);
      check("restart_idx11", hs_idx_q[11], 15);
    end
    check("restart_done", done_cyc, start_cyc + 15);

    // Reset on the third issued read aborts the pass.
    for (int i = 0; i < ACT_NO; i++) rf_mem[i] = DATA_WIDTH'(i + 100);
    clear_logs();
    @(posedge clk); #1 in_act_zeros = '0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_reads", rd_cnt, 3);
    check("abort_valid", act_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_idx", act_idx, 0);
    repeat (5) @(posedge clk);
    #1 check("abort_no_done", done_cyc, -1);
    clear_logs();
    pulse_start(16'h0000);
    wait_done("rerun_timeout");
    check("rerun_count", hs_idx_q.size(), 16);
    if (hs_idx_q.size() != 0) check("rerun_first_idx", hs_idx_q[0], 0);
    check("rerun_done", done_cyc, start_cyc + 19);

    // Single entry at idx 15 held under backpressure.
    rf_mem[15] = 16'hBEEF;
    act_ready  = 1'b0;
    clear_logs();
    pulse_start(16'h7FFF);
    for (int n = 0; n < 50 && first_valid_cyc < 0; n++) @(posedge clk);
    if (first_valid_cyc < 0) check("single_valid_timeout", 0, 1);
    repeat (5) @(posedge clk);
    #1 act_ready = 1'b1;
    wait_done("single_timeout");
    check("single_count", hs_idx_q.size(), 1);
    if (hs_idx_q.size() != 0) check("single_idx", hs_idx_q[0], 15);
    check("single_first_valid", first_valid_cyc, start_cyc + 3);
    check("single_stall_len", (last_hs_cyc - first_valid_cyc) >= 5, 1);
    check("single_done", done_cyc, last_hs_cyc + 1);
    check("final_drained", exp_q.size() + exp_addr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
